// File: rtl/sram_bus_ctrl_pkg.sv
// Shared definitions for the SRAM bus controller: FSM encoding and response codes.
package sram_bus_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RDATA = 2'd1,
        ST_WRESP = 2'd2
    } state_t;

    localparam logic WR_RESP_OK = 1'b1;

endpackage

// File: rtl/sram_bus_ctrl.sv
// Turns ready/valid read and write bus channels into single-cycle SRAM accesses,
// one transaction outstanding, with alternating arbitration under contention.
module sram_bus_ctrl
    import sram_bus_ctrl_pkg::*;
#(
    parameter int data_width     = 32,
    parameter int addr_width     = 8,
    parameter int bus_addr_width = 32,
    parameter int mask_width     = data_width / 8
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      rd_addr_valid,
    output logic                      rd_addr_ready,
    input  logic [bus_addr_width-1:0] rd_addr,
    output logic                      rd_data_valid,
    input  logic                      rd_data_ready,
    output logic [data_width-1:0]     rd_data,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [bus_addr_width-1:0] wr_addr,
    input  logic [data_width-1:0]     wr_data,
    input  logic [mask_width-1:0]     wr_strobe,
    output logic                      wr_resp_valid,
    input  logic                      wr_resp_ready,
    output logic                      wr_resp,
    output logic                      sram_en,
    output logic                      sram_wen,
    output logic [mask_width-1:0]     sram_wmask,
    output logic [addr_width-1:0]     sram_addr,
    output logic [data_width-1:0]     sram_din,
    input  logic [data_width-1:0]     sram_dout
);

    state_t r_state;
    logic   r_last_was_write;
    logic   w_grant_rd;
    logic   w_grant_wr;

    // Byte-offset and upper address bits are intentionally discarded.
    logic   w_unused_addr_bits;
    assign  w_unused_addr_bits = ^{rd_addr, wr_addr};

    // NOTE: both grants get a default first so no latch is inferred.
    always_comb begin
        w_grant_rd = 1'b0;
        w_grant_wr = 1'b0;
        if (r_state == ST_IDLE) begin
            if (rd_addr_valid && wr_valid) begin
                w_grant_rd = r_last_was_write;
                w_grant_wr = !r_last_was_write;
            end else begin
                w_grant_rd = rd_addr_valid;
                w_grant_wr = wr_valid;
            end
        end
    end

    assign rd_addr_ready = w_grant_rd;
    assign wr_ready      = w_grant_wr;

    // A grant implies the matching valid, so grant == accept this cycle.
    assign sram_en    = w_grant_rd | w_grant_wr;
    assign sram_wen   = w_grant_wr;
    assign sram_wmask = w_grant_wr ? wr_strobe : '0;
    assign sram_addr  = w_grant_wr ? wr_addr[addr_width+1:2] : rd_addr[addr_width+1:2];
    assign sram_din   = wr_data;

    assign rd_data_valid = (r_state == ST_RDATA);
    assign rd_data       = sram_dout;
    assign wr_resp_valid = (r_state == ST_WRESP);
    assign wr_resp       = WR_RESP_OK;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state          <= ST_IDLE;
            r_last_was_write <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_rd) begin
                        r_state          <= ST_RDATA;
                        r_last_was_write <= 1'b0;
                    end else if (w_grant_wr) begin
                        r_state          <= ST_WRESP;
                        r_last_was_write <= 1'b1;
                    end
                end
                ST_RDATA: if (rd_data_ready) r_state <= ST_IDLE;
                ST_WRESP: if (wr_resp_ready) r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_bus_ctrl.sv
// Self-checking bench for sram_bus_ctrl: SRAM behavioural model, directed vectors,
// multi-cycle corner sequences and randomized traffic against a word-array reference.
module tb_sram_bus_ctrl;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int BW = 32;
    localparam int MW = DW / 8;

    logic          clock;
    logic          reset_n;
    logic          rd_addr_valid, rd_addr_ready;
    logic [BW-1:0] rd_addr;
    logic          rd_data_valid, rd_data_ready;
    logic [DW-1:0] rd_data;
    logic          wr_valid, wr_ready;
    logic [BW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [MW-1:0] wr_strobe;
    logic          wr_resp_valid, wr_resp_ready, wr_resp;
    logic          sram_en, sram_wen;
    logic [MW-1:0] sram_wmask;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din;
    logic [DW-1:0] sram_dout;

    int checks   = 0;
    int failures = 0;

    logic [31:0] sram_mem [256];
    logic [31:0] ref_mem  [256];

    sram_bus_ctrl #(.data_width(DW), .addr_width(AW), .bus_addr_width(BW)) dut (
        .clock(clock), .reset_n(reset_n),
        .rd_addr_valid(rd_addr_valid), .rd_addr_ready(rd_addr_ready), .rd_addr(rd_addr),
        .rd_data_valid(rd_data_valid), .rd_data_ready(rd_data_ready), .rd_data(rd_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_strobe(wr_strobe), .wr_resp_valid(wr_resp_valid), .wr_resp_ready(wr_resp_ready),
        .wr_resp(wr_resp), .sram_en(sram_en), .sram_wen(sram_wen), .sram_wmask(sram_wmask),
        .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // SRAM macro: registered read data, held while not enabled or on a write.
    always @(posedge clock) begin
        if (sram_en) begin
            if (sram_wen) begin
                for (int b = 0; b < MW; b++)
                    if (sram_wmask[b]) sram_mem[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
            end else begin
                sram_dout <= sram_mem[sram_addr];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Starts at a negedge; returns after the response handshake edge.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int rdelay);
        int n;
        logic [7:0] w;
        w = a[9:2];
        @(negedge clock);
        wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_strobe = s;
        n = 0;
        #1;
        while (!wr_ready && n < 10) begin @(negedge clock); #1; n++; end
        check("wr_accept_ready", 32'(wr_ready), 32'(1'b1));
        check("wr_sram_en_wen", 32'({sram_en, sram_wen}), 32'(2'b11));
        check("wr_sram_mask", 32'(sram_wmask), 32'(s));
        check("wr_sram_addr", 32'(sram_addr), 32'(w));
        @(posedge clock);
        ref_mem[w] = merge(ref_mem[w], d, s);
        @(negedge clock);
        wr_valid = 1'b0;
        for (int i = 0; i <= rdelay; i++) begin
            if (i > 0) @(negedge clock);
            #1;
            check("wr_resp_valid", 32'(wr_resp_valid), 32'(1'b1));
            check("wr_resp_ok", 32'(wr_resp), 32'(1'b1));
            check("wr_resp_sram_idle", 32'({sram_en, sram_wen, sram_wmask}), 32'(0));
        end
        wr_resp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        wr_resp_ready = 1'b0;
    endtask

    task automatic do_read(input string name, input logic [31:0] a, input logic [31:0] exp,
                           input int rdelay);
        int n;
        @(negedge clock);
        rd_addr_valid = 1'b1; rd_addr = a;
        n = 0;
        #1;
        while (!rd_addr_ready && n < 10) begin @(negedge clock); #1; n++; end
        check("rd_accept_ready", 32'(rd_addr_ready), 32'(1'b1));
        check("rd_sram_en_wen", 32'({sram_en, sram_wen}), 32'(2'b10));
        check("rd_sram_addr", 32'(sram_addr), 32'(a[9:2]));
        @(posedge clock);
        @(negedge clock);
        rd_addr_valid = 1'b0;
        for (int i = 0; i <= rdelay; i++) begin
            if (i > 0) @(negedge clock);
            #1;
            check("rd_data_valid", 32'(rd_data_valid), 32'(1'b1));
            check(name, rd_data, exp);
        end
        rd_data_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        rd_data_ready = 1'b0;
    endtask

    typedef struct {
        string       name;
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [31:0] held;
        int          n;
        logic        got_rd;

        rd_addr_valid = 0; rd_addr = '0; rd_data_ready = 0;
        wr_valid = 0; wr_addr = '0; wr_data = '0; wr_strobe = '0; wr_resp_ready = 0;
        reset_n = 1'b0;

        vecs[0] = '{"w_deadbeef",  1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0};
        vecs[1] = '{"r_deadbeef",  1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF};
        vecs[2] = '{"w_partial",   1'b1, 32'h10,  32'h11223344, 4'h5, 32'h0};
        vecs[3] = '{"r_partial",   1'b0, 32'h13,  32'h0,        4'h0, 32'hDE22BE44};
        vecs[4] = '{"w_wrap",      1'b1, 32'h400, 32'hCAFEF00D, 4'hF, 32'h0};
        vecs[5] = '{"r_wrap_alias",1'b0, 32'h0,   32'h0,        4'h0, 32'hCAFEF00D};
        vecs[6] = '{"w_nostrobe",  1'b1, 32'h0,   32'hFFFFFFFF, 4'h0, 32'h0};
        vecs[7] = '{"r_nostrobe",  1'b0, 32'hFFFFFC03, 32'h0,   4'h0, 32'hCAFEF00D};

        repeat (2) @(negedge clock);
        #1;
        check("rst_rd_addr_ready", 32'(rd_addr_ready), 32'(0));
        check("rst_wr_ready", 32'(wr_ready), 32'(0));
        check("rst_rd_data_valid", 32'(rd_data_valid), 32'(0));
        check("rst_wr_resp_valid", 32'(wr_resp_valid), 32'(0));
        check("rst_wr_resp", 32'(wr_resp), 32'(1));
        check("rst_sram_ctrl", 32'({sram_en, sram_wen, sram_wmask}), 32'(0));
        @(negedge clock);
        reset_n = 1'b1;

        // Prefill so every word has a known value in both SRAM and reference.
        for (int i = 0; i < 256; i++) do_write(32'(i) << 2, 32'(i) * 32'h01010101 ^ 32'h5A000000, 4'hF, 0);

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].is_wr) do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 1);
            else               do_read(vecs[i].name, vecs[i].addr, vecs[i].exp, 0);
        end

        // Contention: last transaction was a write, so grants go R, W, R, W.
        do_write(32'h20, 32'h0BADF00D, 4'hF, 0);
        rd_addr_valid = 1'b1; rd_addr = 32'h10;
        wr_valid = 1'b1; wr_addr = 32'h20; wr_data = 32'h5A5A1234; wr_strobe = 4'hF;
        for (int g = 0; g < 4; g++) begin
            n = 0;
            #1;
            while (!(rd_addr_ready || wr_ready) && n < 10) begin @(negedge clock); #1; n++; end
            check("arb_grant_rd", 32'(rd_addr_ready), 32'(g % 2 == 0));
            check("arb_grant_wr", 32'(wr_ready), 32'(g % 2 == 1));
            got_rd = rd_addr_ready;
            @(posedge clock);
            if (!got_rd) ref_mem[8] = 32'h5A5A1234;
            @(negedge clock);
            #1;
            if (got_rd) begin
                check("arb_rd_data", rd_data, ref_mem[4]);
                rd_data_ready = 1'b1;
            end else begin
                check("arb_wr_resp_valid", 32'(wr_resp_valid), 32'(1));
                wr_resp_ready = 1'b1;
            end
            check("arb_no_accept_in_hs", 32'({rd_addr_ready, wr_ready}), 32'(0));
            @(posedge clock);
            @(negedge clock);
            rd_data_ready = 1'b0; wr_resp_ready = 1'b0;
        end
        rd_addr_valid = 1'b0; wr_valid = 1'b0;
        do_read("arb_wr_landed", 32'h20, 32'h5A5A1234, 0);

        // Backpressure: response held 5 cycles while a write waits.
        rd_addr_valid = 1'b1; rd_addr = 32'h10;
        @(posedge clock);
        @(negedge clock);
        rd_addr_valid = 1'b0;
        wr_valid = 1'b1; wr_addr = 32'h30; wr_data = 32'h77777777; wr_strobe = 4'hF;
        #1;
        held = rd_data;
        check("bp_first_data", held, 32'hDE22BE44);
        for (int c = 0; c < 5; c++) begin
            #1;
            check("bp_valid_held", 32'(rd_data_valid), 32'(1));
            check("bp_data_stable", rd_data, held);
            check("bp_readies_low", 32'({rd_addr_ready, wr_ready, sram_en}), 32'(0));
            @(negedge clock);
        end
        wr_valid = 1'b0;
        rd_data_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        rd_data_ready = 1'b0;

        // Reset during WRESP drops the response asynchronously.
        wr_valid = 1'b1; wr_addr = 32'h44; wr_data = 32'h13579BDF; wr_strobe = 4'hF;
        #1;
        check("rst_wr_accept", 32'(wr_ready), 32'(1));
        @(posedge clock);
        ref_mem[17] = 32'h13579BDF;
        @(negedge clock);
        wr_valid = 1'b0;
        #1;
        check("rst_wresp_before", 32'(wr_resp_valid), 32'(1));
        #1 reset_n = 1'b0;
        #1;
        check("rst_wresp_async_drop", 32'(wr_resp_valid), 32'(0));
        check("rst_rdata_low", 32'(rd_data_valid), 32'(0));
        @(negedge clock);
        reset_n = 1'b1;
        rd_addr_valid = 1'b1; rd_addr = 32'h44;
        #1;
        check("rst_next_accept", 32'(rd_addr_ready), 32'(1));
        @(posedge clock);
        @(negedge clock);
        rd_addr_valid = 1'b0;
        #1;
        check("rst_read_after", rd_data, 32'h13579BDF);
        rd_data_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        rd_data_ready = 1'b0;

        // Randomized traffic against the word-array reference.
        for (int i = 0; i < 80; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 1) == 1)
                do_write(a, $urandom, 4'($urandom), $urandom_range(0, 3));
            else
                do_read("rand_rd_data", a, ref_mem[a[9:2]], $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
